// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between pipeline datapath (master) and the stall/flush sequencer (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             id_valid;
    logic [4:0]       ex_rd;
    logic             ex_memread;
    logic             ex_valid;
    logic             ex_redirect;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_stall;
    logic             idex_flush;
    logic             exmem_stall;
    logic             memwb_flush;
    logic             mem_err;
    logic             busy_wait;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_valid,
               ex_rd, ex_memread, ex_valid, ex_redirect, mem_req, mem_ready,
        input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, memwb_flush, mem_err, busy_wait, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_valid,
               ex_rd, ex_memread, ex_valid, ex_redirect, mem_req, mem_ready,
        output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, memwb_flush, mem_err, busy_wait, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, EX redirects,
// data-memory wait tracking with timeout, and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hz
);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_ERR} state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt, wait_inc;
    logic              mem_err_q, mem_err_nxt;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    logic mem_stall, load_use, redirect_take;
    logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush;

    // State, wait timer, error pulse and performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            mem_err_q <= mem_err_nxt;
            if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (redirect_take && (flush_cnt_q != {CNT_W{1'b1}}))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    // Hazard detection, prioritised controls and next-state logic
    always_comb begin
        pc_stall      = 1'b0;
        ifid_stall    = 1'b0;
        ifid_flush    = 1'b0;
        idex_stall    = 1'b0;
        idex_flush    = 1'b0;
        exmem_stall   = 1'b0;
        memwb_flush   = 1'b0;
        redirect_take = 1'b0;
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        mem_err_nxt   = 1'b0;

        mem_stall = hz.mem_req & ~hz.mem_ready;
        load_use  = hz.ex_valid & hz.ex_memread & hz.id_valid & (hz.ex_rd != 5'd0) &
                    ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                     (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));
        // wait_cnt is zero in RUN, so the same increment starts a fresh access at 1
        wait_inc  = wait_cnt + WAIT_W'(1);

        if (reset) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end else if ((state == ST_ERR) || mem_stall) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
        end else if (hz.ex_redirect) begin
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            redirect_take = 1'b1;
        end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
        end

        case (state)
            ST_RUN, ST_WAIT: begin
                if (mem_stall) begin
                    if (32'(wait_inc) >= MEM_TIMEOUT) begin
                        state_nxt   = ST_ERR;
                        mem_err_nxt = 1'b1;
                    end else begin
                        state_nxt    = ST_WAIT;
                        wait_cnt_nxt = wait_inc;
                    end
                end else begin
                    // completion or withdrawn access both end the wait
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end
            end
            ST_ERR:  state_nxt = ST_ERR;
            default: begin
                state_nxt    = ST_RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    assign hz.pc_stall    = pc_stall;
    assign hz.ifid_stall  = ifid_stall;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_stall  = idex_stall;
    assign hz.idex_flush  = idex_flush;
    assign hz.exmem_stall = exmem_stall;
    assign hz.memwb_flush = memwb_flush;
    assign hz.mem_err     = mem_err_q;
    assign hz.busy_wait   = (state == ST_WAIT);
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;
endmodule
